hex_entry_assembler: RTL

Converts ASCII characters from the UART receive path into the 24-bit hex value that drives the six-digit seven-segment display controller. It accumulates hex digits typed by the user, supports backspace and cancel, and commits the value on carriage return or line feed. It sits between the UART RX byte interface and the display controller's 24-bit num input. It also exports the in-progress value so the display can echo digits as they are typed.

---
 rtl/hex_entry_assembler.sv | 113 +++++++++++
 1 files changed

// File: rtl/hex_entry_assembler.sv
// Accumulates typed ASCII hex digits into a right-aligned value and commits it on CR/LF.
// Latency 1 cycle from rx_valid; no backpressure, so every strobed byte is consumed.
module hex_entry_assembler #(
  parameter int DIGITS = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic [4*DIGITS-1:0]   num,
  output logic [4*DIGITS-1:0]   entry,
  output logic [2:0]            digit_cnt,
  output logic                  num_valid,
  output logic                  err,
  output logic                  entering
);

  localparam int         W      = 4 * DIGITS;
  localparam logic [2:0] MAXCNT = 3'(DIGITS);

  typedef enum logic {IDLE, ENTRY} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   num_q, num_d;
  logic [W-1:0]   entry_q, entry_d;
  logic [2:0]     cnt_q, cnt_d;
  logic           nv_q, nv_d;
  logic           err_q, err_d;
  logic           is_hex;
  logic [3:0]     nibble;

  always_comb begin
    is_hex = 1'b0;
    nibble = 4'h0;
    if (rx_data >= 8'h30 && rx_data <= 8'h39) begin
      is_hex = 1'b1;
      nibble = rx_data[3:0];
    end else if ((rx_data >= 8'h41 && rx_data <= 8'h46) ||
                 (rx_data >= 8'h61 && rx_data <= 8'h66)) begin
      // Low nibble of 'A'/'a' is 1, so adding 9 yields 10..15.
      is_hex = 1'b1;
      nibble = rx_data[3:0] + 4'd9;
    end
  end

  always_comb begin
    num_d   = num_q;
    entry_d = entry_q;
    cnt_d   = cnt_q;
    nv_d    = 1'b0;
    err_d   = 1'b0;
    if (rx_valid) begin
      if (is_hex) begin
        if (cnt_q < MAXCNT) begin
          entry_d = (entry_q << 4) | {{(W-4){1'b0}}, nibble};
          cnt_d   = cnt_q + 3'd1;
        end else begin
          err_d = 1'b1;
        end
      end else begin
        case (rx_data)
          8'h0D, 8'h0A: begin
            // A bare terminator (e.g. the LF of CR LF) is silently ignored.
            if (state_q == ENTRY) begin
              num_d   = entry_q;
              nv_d    = 1'b1;
              entry_d = '0;
              cnt_d   = 3'd0;
            end
          end
          8'h08, 8'h7F: begin
            if (state_q == ENTRY) begin
              entry_d = entry_q >> 4;
              cnt_d   = cnt_q - 3'd1;
            end
          end
          8'h1B: begin
            entry_d = '0;
            cnt_d   = 3'd0;
          end
          default: err_d = 1'b1;
        endcase
      end
    end
    state_d = (cnt_d != 3'd0) ? ENTRY : IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      num_q   <= '0;
      entry_q <= '0;
      cnt_q   <= 3'd0;
      nv_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      entry_q <= entry_d;
      cnt_q   <= cnt_d;
      nv_q    <= nv_d;
      err_q   <= err_d;
    end
  end

  assign num       = num_q;
  assign entry     = entry_q;
  assign digit_cnt = cnt_q;
  assign num_valid = nv_q;
  assign err       = err_q;
  assign entering  = (state_q == ENTRY);

endmodule
